ghpc_and_scheduler: RTL and testbench



---
 rtl/ghpc_pkg.sv | 17 +
 rtl/ghpc_and_d1.sv | 77 +++++++
 rtl/ghpc_and_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_ghpc_and_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ghpc_pkg.sv
// Shared types and constants for the GHPC AND scheduler slice.
// Build macro: GHPC_OUT_REG_EN adds an output register stage to the gadget.
package ghpc_pkg;

    typedef logic [1:0] share_t;

`ifdef GHPC_OUT_REG_EN
    localparam int GHPC_LAT = 3;
`else
    localparam int GHPC_LAT = 2;
`endif

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ghpc_and_d1.sv
// First-order (2-share) GHPC masked AND gadget, fixed latency GHPC_LAT, no stall.
// Build macro: GHPC_OUT_REG_EN registers both result shares once more.
module ghpc_and_d1
    import ghpc_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  share_t a,
    input  share_t b,
    input  logic   r,
    output share_t d
);

    logic [3:0] t_s;
    logic [3:0] t_r;
    logic       a1_r;
    logic       b1_r;
    logic       r1_r;
    logic       d1_r;
    logic       r2_r;

    // Step1 terms: f(a0^x, b0^y)^r precomputed for every value {x,y} of the share-1 pair
    always_comb begin
        t_s    = 4'b0000;
        t_s[0] = ( a[0] &  b[0]) ^ r;
        t_s[1] = ( a[0] & ~b[0]) ^ r;
        t_s[2] = (~a[0] &  b[0]) ^ r;
        t_s[3] = (~a[0] & ~b[0]) ^ r;
    end

    // Step1 registers: precomputed terms, share-1 selectors and the mask
    always_ff @(posedge clk) begin
        if (rst) begin
            t_r  <= 4'b0000;
            a1_r <= 1'b0;
            b1_r <= 1'b0;
            r1_r <= 1'b0;
        end else begin
            t_r  <= t_s;
            a1_r <= a[1];
            b1_r <= b[1];
            r1_r <= r;
        end
    end

    // Step2 registers: share-1 values select the matching term, mask becomes d0
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_r <= 1'b0;
            r2_r <= 1'b0;
        end else begin
            d1_r <= t_r[{a1_r, b1_r}];
            r2_r <= r1_r;
        end
    end

`ifdef GHPC_OUT_REG_EN
    logic d1_o_r;
    logic d0_o_r;

    // Optional output stage on both result shares
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_o_r <= 1'b0;
            d0_o_r <= 1'b0;
        end else begin
            d1_o_r <= d1_r;
            d0_o_r <= r2_r;
        end
    end

    assign d = {d1_o_r, d0_o_r};
`else
    assign d = {d1_r, r2_r};
`endif

endmodule

// File: rtl/ghpc_and_scheduler.sv
// Round-robin scheduler sharing one GHPC AND gadget among N_REQ requesters.
// Build macro: GHPC_OUT_REG_EN (gadget latency 3 instead of 2).
module ghpc_and_scheduler
    import ghpc_pkg::*;
#(
    parameter int  N_REQ      = 4,
    parameter int  FIFO_DEPTH = 4,
    localparam int ID_W       = id_width(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_a,
    input  logic [2*N_REQ-1:0]   req_b,
    input  logic                 rnd_valid,
    input  logic                 rnd_bit,
    output logic                 rnd_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_d,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  grant_s;
    logic [ID_W-1:0]  grant_next_s;
    logic [ID_W:0]    cand_s;
    logic             any_req_s;
    logic [CNT_W:0]   occ_s;
    logic             credit_s;
    logic             issue_s;
    logic [N_REQ-1:0] req_ready_s;

    share_t           gad_a_s;
    share_t           gad_b_s;
    logic             gad_r_s;
    share_t           gad_d_s;

    logic [GHPC_LAT-1:0] sr_valid_r;
    logic [ID_W-1:0]     sr_id_r [GHPC_LAT];

    logic [CNT_W-1:0] in_flight_r;
    logic [CNT_W-1:0] fifo_count_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    share_t           mem_d_r  [FIFO_DEPTH];
    logic [ID_W-1:0]  mem_id_r [FIFO_DEPTH];
    logic             push_s;
    logic             pop_s;

    // Cyclic search for the first requester at or after rr_ptr
    always_comb begin
        grant_s   = '0;
        any_req_s = 1'b0;
        cand_s    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
            if (cand_s >= (ID_W+1)'(N_REQ)) begin
                cand_s = cand_s - (ID_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!any_req_s && req_valid[cand_s[ID_W-1:0]]) begin
                any_req_s = 1'b1;
                grant_s   = cand_s[ID_W-1:0];
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

    // Credits cover both in-flight and buffered results, so the FIFO never overflows
    assign occ_s    = {1'b0, in_flight_r} + {1'b0, fifo_count_r};
    assign credit_s = (occ_s < (CNT_W+1)'(FIFO_DEPTH));
    assign issue_s  = any_req_s && rnd_valid && credit_s;

    // Handshakes, pointer increment and the gadget operand mux (zeros when idle)
    always_comb begin
        req_ready_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_s[i] = issue_s && (grant_s == ID_W'(i));
        end
        if (grant_s == ID_W'(N_REQ - 1)) begin
            grant_next_s = '0;
        end else begin
            grant_next_s = grant_s + ID_W'(1);
        end
        if (issue_s) begin
            gad_a_s = req_a[{grant_s, 1'b0} +: 2];
            gad_b_s = req_b[{grant_s, 1'b0} +: 2];
            gad_r_s = rnd_bit;
        end else begin
            gad_a_s = 2'b00;
            gad_b_s = 2'b00;
            gad_r_s = 1'b0;
        end
    end

    assign req_ready = req_ready_s;
    assign rnd_ready = issue_s;

    // Round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (issue_s) begin
            rr_ptr_r <= grant_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    ghpc_and_d1 u_gadget (
        .clk (clk),
        .rst (rst),
        .a   (gad_a_s),
        .b   (gad_b_s),
        .r   (gad_r_s),
        .d   (gad_d_s)
    );

    // id/valid shift register matching the gadget latency
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_valid_r <= '0;
            for (int i = 0; i < GHPC_LAT; i++) begin
                sr_id_r[i] <= '0;
            end
        end else begin
            sr_valid_r <= {sr_valid_r[GHPC_LAT-2:0], issue_s};
            sr_id_r[0] <= grant_s;
            for (int i = 1; i < GHPC_LAT; i++) begin
                sr_id_r[i] <= sr_id_r[i-1];
            end
        end
    end

    assign push_s = sr_valid_r[GHPC_LAT-1];
    assign pop_s  = res_valid && res_ready;

    // In-flight credit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_r <= '0;
        end else begin
            case ({issue_s, push_s})
                2'b10:   in_flight_r <= in_flight_r + CNT_W'(1);
                2'b01:   in_flight_r <= in_flight_r - CNT_W'(1);
                default: in_flight_r <= in_flight_r;
            endcase
        end
    end

    // Result FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_d_r[i]  <= 2'b00;
                mem_id_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_d_r[wr_ptr_r]  <= gad_d_s;
                mem_id_r[wr_ptr_r] <= sr_id_r[GHPC_LAT-1];
                wr_ptr_r <= (wr_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    assign res_valid = (fifo_count_r != '0);
    assign res_d     = mem_d_r[rd_ptr_r];
    assign res_id    = mem_id_r[rd_ptr_r];
    assign busy      = (in_flight_r != '0) || (fifo_count_r != '0);

endmodule

// File: tb/tb_ghpc_and_scheduler.sv
// Scoreboard bench for ghpc_and_scheduler: directed stimulus pushes expected results,
// an independent monitor pops and compares on every accepted result.
module tb_ghpc_and_scheduler;
    import ghpc_pkg::*;

`ifdef GHPC_OUT_REG_EN
    localparam int FD = 5;
`else
    localparam int FD = 4;
`endif

    typedef struct {
        logic [1:0] id;
        logic       d0;
        logic       dv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rnd_valid;
    logic       rnd_bit;
    logic       rnd_ready;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_d;
    logic [1:0] res_id;
    logic       busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;
    int   exp_ptr  = 0;

    always #5 clk = ~clk;

    ghpc_and_scheduler #(.N_REQ(4), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rnd_valid (rnd_valid),
        .rnd_bit   (rnd_bit),
        .rnd_ready (rnd_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_d     (res_d),
        .res_id    (res_id),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result is compared against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got id=%0d d=%b expected none", res_id, res_d);
            end else begin
                e = sb.pop_front();
                check("res_id", 32'(res_id), 32'(e.id));
                check("res_d0", 32'(res_d[0]), 32'(e.d0));
                check("res_unmasked", 32'(res_d[1] ^ res_d[0]), 32'(e.dv));
            end
        end
    end

    // One cycle: check handshakes, push expectation on issue, advance to posedge+1
    task automatic step(input logic [3:0] exp_ready, input logic exp_rnd);
        exp_t e;
        int   g;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rnd_ready", 32'(rnd_ready), 32'(exp_rnd));
        if (exp_ready == 4'b0000) begin
            check("gadget_idle", 32'({dut.gad_a_s, dut.gad_b_s, dut.gad_r_s}), 32'd0);
        end else begin
            g = 0;
            for (int i = 0; i < 4; i++) if (exp_ready[i]) g = i;
            e.id = 2'(g);
            e.d0 = rnd_bit;
            e.dv = (^req_a[2*g +: 2]) & (^req_b[2*g +: 2]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // All requesters valid: expected grant follows the bench's own pointer model
    task automatic issue_rr();
        logic [3:0] oh;
        oh = 4'b0001 << exp_ptr;
        step(oh, 1'b1);
        exp_ptr = (exp_ptr + 1) % 4;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 40 && (busy || res_valid); k++) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'({busy, res_valid}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [4:0] cv;
        int q;
        rst = 1'b1; req_valid = 4'b0; req_a = 8'h00; req_b = 8'h00;
        rnd_valid = 1'b0; rnd_bit = 1'b0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rnd_ready", 32'(rnd_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_d", 32'(res_d), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single operation, issued in the first cycle after reset release
        req_valid = 4'b0001; req_a = 8'h02; req_b = 8'h01;
        rnd_valid = 1'b1; rnd_bit = 1'b1;
        step(4'b0001, 1'b1);
        req_valid = 4'b0000;
        for (int k = 1; k <= GHPC_LAT + 1; k++) begin
            @(negedge clk);
            check("single_latency", 32'(res_valid), 32'(k == GHPC_LAT + 1));
            @(posedge clk);
            #1;
        end
        wait_idle("single_drain");
        for (int k = 0; k < 2; k++) step(4'b0000, 1'b0);

        // Fairness from a reset pointer
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; exp_ptr = 0;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            req_a = 8'h1B ^ 8'(i * 37); req_b = 8'hC6 ^ 8'(i * 11);
            rnd_bit = 1'(i);
            issue_rr();
        end
        req_valid = 4'b0000;
        wait_idle("fair_drain");

        // Randomness starvation
        req_valid = 4'b1111; rnd_valid = 1'b0;
        for (int k = 0; k < 5; k++) step(4'b0000, 1'b0);
        check("starve_rr_ptr", 32'(dut.rr_ptr_r), 32'(exp_ptr));
        rnd_valid = 1'b1; rnd_bit = 1'b0; req_a = 8'h9C; req_b = 8'h5A;
        issue_rr();
        req_valid = 4'b0000;
        wait_idle("starve_drain");

        // Backpressure: exactly FD issues, then stall until results drain
        res_ready = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < FD; i++) begin
            req_a = 8'h35 + 8'(i); req_b = 8'hE1 - 8'(i); rnd_bit = ~rnd_bit;
            issue_rr();
        end
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);
        check("bp_full_valid", 32'(res_valid), 32'd1);
        req_valid = 4'b0000; p0 = n_pop; res_ready = 1'b1;
        wait_idle("bp_drain");
        check("bp_pop_count", 32'(n_pop - p0), 32'(FD));
        req_valid = 4'b1111;
        issue_rr();
        req_valid = 4'b0000;
        wait_idle("bp_resume_drain");

        // Every share combination of a, b and r through each requester slot
        for (int c = 0; c < 32; c++) begin
            cv = 5'(c);
            q = c % 4;
            req_a = {4{~cv[4:3]}}; req_b = {4{~cv[2:1]}};
            req_a[2*q +: 2] = cv[4:3]; req_b[2*q +: 2] = cv[2:1];
            rnd_bit = cv[0];
            req_valid = 4'b0001 << q;
            step(4'b0001 << q, 1'b1);
            exp_ptr = (q + 1) % 4;
            req_valid = 4'b0000;
            step(4'b0000, 1'b0);
        end
        wait_idle("exh_drain");

        // Reset with two in flight and one buffered
        res_ready = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) issue_rr();
        req_valid = 4'b0000; rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0; exp_ptr = 0; res_ready = 1'b1;
        @(negedge clk);
        check("rstmid_res_valid", 32'(res_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rr_ptr", 32'(dut.rr_ptr_r), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rstmid_no_stale", 32'(res_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0010; req_a = 8'h0C; req_b = 8'h04; rnd_bit = 1'b1;
        step(4'b0010, 1'b1);
        req_valid = 4'b0000;
        wait_idle("final_drain");
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
